// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver for the cpu_clk (6 MHz) domain.
// Synchronises and de-glitches the raw PS/2 pins, deserialises 11-bit
// device-to-host frames with odd-parity and stop-bit checking, and folds
// the E0 (extended) and F0 (break) prefixes into a single key event.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   byte_data    last correctly received raw byte
//   byte_valid   one-cycle pulse when byte_data updates
//   key_code     scancode of the last completed key event
//   key_ext      key event was preceded by E0
//   key_release  key event was preceded by F0
//   key_valid    one-cycle pulse when the key_* fields update
//   parity_err   one-cycle pulse on an odd-parity failure
//   frame_err    one-cycle pulse on a bad stop bit or a mid-frame timeout
//   busy         high while the deserialiser is inside a frame
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_REL = 8'hF0;

  logic       clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic       filt_clk_q, filt_clk_d;
  logic [7:0] filt_cnt_q, filt_cnt_d;
  logic       fall_q, fall_d;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        parity_q, parity_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;

  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_release_q, key_release_d;
  logic       key_valid_q, key_valid_d;
  logic       parity_err_q, parity_err_d;
  logic       frame_err_q, frame_err_d;
  logic       good_byte;

  // Glitch filter: the filtered clock only follows the synchronised clock
  // after FILTER_LEN consecutive mismatching samples. A 1->0 toggle raises
  // the registered fall pulse in the following cycle.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        filt_clk_d = ~filt_clk_q;
        fall_d     = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  // Deserialiser, timeout and prefix folding. A fall event in the same
  // cycle as an expiring timeout resets the counter, so the fall wins.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    parity_d      = parity_q;
    tmo_cnt_d     = tmo_cnt_q;
    ext_d         = ext_q;
    rel_d         = rel_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_valid_d   = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    good_byte     = 1'b0;

    if (state_q == S_IDLE || fall_q) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_MAX) begin
      tmo_cnt_d   = '0;
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    if (fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {data_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!data_s2_q) begin
            frame_err_d = 1'b1;
          end else if ((^shift_q ^ parity_q) == 1'b0) begin
            parity_err_d = 1'b1;
          end else begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            good_byte    = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (good_byte) begin
      if (shift_q == BYTE_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q == BYTE_REL) begin
        rel_d = 1'b1;
      end else begin
        key_code_d    = shift_q;
        key_ext_d     = ext_q;
        key_release_d = rel_q;
        key_valid_d   = 1'b1;
        ext_d         = 1'b0;
        rel_d         = 1'b0;
      end
    end

    // A damaged frame may have been the key byte a prefix belonged to.
    if (parity_err_d || frame_err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      data_s1_q     <= 1'b1;
      data_s2_q     <= 1'b1;
      filt_clk_q    <= 1'b1;
      filt_cnt_q    <= '0;
      fall_q        <= 1'b0;
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_valid_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      clk_s1_q      <= ps2_clk;
      clk_s2_q      <= clk_s1_q;
      data_s1_q     <= ps2_data;
      data_s2_q     <= data_s1_q;
      filt_clk_q    <= filt_clk_d;
      filt_cnt_q    <= filt_cnt_d;
      fall_q        <= fall_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      ext_q         <= ext_d;
      rel_q         <= rel_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_valid_q   <= key_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_valid   = key_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of keypad, in the cpu_clk domain at 6 MHz.
- Synchronises and de-glitches the raw ps2_clk and ps2_data pins.
- Deserialises 11-bit device-to-host frames and checks parity and framing.
- Folds the E0 (extended) and F0 (break) prefixes into one key event per keystroke.
- keypad consumes key_valid, key_code, key_ext and key_release to update its row/column matrix and reset request.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples needed before the filtered ps2_clk changes level (range 2..255).
TIMEOUT_CYCLES, 6000, clk cycles with no filtered falling edge, while inside a frame, before the frame is abandoned (~1 ms at 6 MHz; range 1..65535).

Ports:
clk  in  1  system clock (cpu_clk, 6 MHz)
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
byte_data  out  8  last correctly received raw byte
byte_valid  out  1  one-cycle pulse: byte_data updated
key_code  out  8  scancode of the completed key event
key_ext  out  1  key event was preceded by E0
key_release  out  1  key event was preceded by F0
key_valid  out  1  one-cycle pulse: key_* fields valid
parity_err  out  1  one-cycle pulse: odd-parity check failed
frame_err  out  1  one-cycle pulse: stop bit was 0, or timeout
busy  out  1  high while the deserialiser is not IDLE

Behaviour:
Clock and reset:
- One clock, clk; reset is synchronous and active-high.
- Reset overrides everything, including a frame in progress.
- Reset values: state=IDLE, filtered clock=1, filter count=0, shift register=0, bit count=0, timeout count=0, ext_pending=0, rel_pending=0.
- Every output resets to 0, including byte_data and key_code.

Input conditioning:
- ps2_clk and ps2_data each pass through a 2-flop synchroniser; both synchroniser resets are 1.
- Filter: a counter increments while the synchronised clock differs from the filtered level and clears when they match.
- When the counter reaches FILTER_LEN-1 and the mismatch is still present, the filtered level toggles and the counter clears.
- A filtered 1->0 transition is a "fall" event: a single registered pulse in the cycle after the toggle. Synchronised data is sampled in that same cycle.

Deserialiser FSM (acts only on fall events, plus the timeout):
- IDLE: on fall, data=0 -> DATA with bit count=0; data=1 -> stay IDLE (spurious start, no error).
- DATA: shift data in LSB first. After the 8th bit -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: on fall, always return to IDLE, and in the next cycle:
  - data=0: frame_err pulses (takes priority over the parity check).
  - data=1 and XOR(8 data bits, parity) = 0: parity_err pulses.
  - data=1 and XOR(8 data bits, parity) = 1: byte_data updates and byte_valid pulses.
- Timeout: the counter clears on every fall and in IDLE, and counts in any other state.
  - Reaching TIMEOUT_CYCLES -> IDLE, with frame_err pulsing in the next cycle.
  - A fall event in the same cycle wins and the timeout does not fire.
- busy = (state != IDLE).

Prefix layer (acts on byte_valid):
- Byte E0: set ext_pending; no key_valid.
- Byte F0: set rel_pending; no key_valid.
- Any other byte: in the same cycle as byte_valid, key_code=byte, key_ext=ext_pending, key_release=rel_pending and key_valid pulses; both pendings clear.
- A repeated E0 or F0 leaves that flag set.
- Any parity_err or frame_err clears both pendings.
- key_code, key_ext and key_release hold until the next key_valid.

Latency and throughput:
- byte_valid and key_valid pulse exactly 1 cycle after the fall event that samples the stop bit.
- No backpressure: the consumer must accept every pulse.
- Frames arrive at least ~600 cycles apart, so no buffering is required.

Test Plan:
1. Valid frame 0x1C: start 0, bits LSB first, parity 0, stop 1, PS/2 clock 12.5 kHz -> exactly one byte_valid and one key_valid; byte_data=0x1C, key_code=0x1C, key_ext=0, key_release=0, busy low afterwards.
2. Frames F0 then 1C -> a single key_valid with key_code=0x1C, key_release=1, key_ext=0. Frames E0,F0,75 -> one key_valid with key_code=0x75, key_ext=1, key_release=1. Two byte_valid pulses in the first case, three in the second.
3. Frame 0x1C with parity bit 1, followed by frame 0x1C -> parity_err pulses once, no key_valid for the first frame. Precede the bad frame with F0 -> the later 0x1C reports key_release=0 (pending cleared).
4. Frame with stop bit 0 -> frame_err pulses, no byte_valid. Separately, stop ps2_clk after 4 data bits -> frame_err exactly TIMEOUT_CYCLES(+1 pulse cycle) after the last fall, busy drops, and a following valid 0x29 frame decodes correctly.
5. Low glitches on ps2_clk of FILTER_LEN-2 cycles inserted mid-frame -> no extra bits sampled, correct byte received. A FILTER_LEN+2 glitch -> bit misalignment and an error, never a bogus key_valid with the correct parity.
6. Assert reset for 1 cycle mid-frame (after 5 bits), then send a valid 0x5A frame -> all outputs 0 during reset, no pulse from the aborted frame, 0x5A decoded with key_ext=0 and key_release=0.
